// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the layer sequencer: state encodings, default watchdog
// limit and a small classification helper.
package nn_ctrl_pkg;

    localparam int DEFAULT_TIMEOUT = 65535;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POOL   = 3'd1,
        S_DENSE1 = 3'd2,
        S_DENSE2 = 3'd3,
        S_ARGMAX = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } nn_state_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POOL   = 3'd1;
    localparam logic [2:0] ST_DENSE1 = 3'd2;
    localparam logic [2:0] ST_DENSE2 = 3'd3;
    localparam logic [2:0] ST_ARGMAX = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    // True for the four states that wait on an external compute stage.
    function automatic logic is_stage(input logic [2:0] s);
        return (s >= ST_POOL) && (s <= ST_ARGMAX);
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle counter; expired is high during the TIMEOUT-th cycle a stage
// has been occupied.
module stage_watchdog
    import nn_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int          W     = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Counter holds 0 in a stage's first cycle, so it equals LIMIT in cycle TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && (cnt != LIMIT)) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign expired = count && (cnt == LIMIT);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Run controller for the digit-recognition pipeline: launches pool, two dense
// layers and argmax in turn, with a per-stage watchdog and run cycle counter.
module nn_layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pool_done,
    input  logic             dense1_done,
    input  logic             dense2_done,
    input  logic             max_done,
    input  logic [7:0]       max_digit,
    output logic             pool_start,
    output logic             dense1_start,
    output logic             dense2_start,
    output logic             max_start,
    output logic             busy,
    output logic [7:0]       digit_out,
    output logic             nn_done,
    output logic             timeout_err,
    output logic [2:0]       stage,
    output logic [CNT_W-1:0] cycle_count
);

    logic [2:0] state_r;
    logic [2:0] next_s;
    logic [2:0] succ_s;
    logic       done_s;
    logic       expired_s;
    logic       accept_s;

    assign stage    = state_r;
    assign accept_s = (state_r == ST_IDLE) && start;

    // The launch pulse marks a stage's first cycle, so it doubles as the done mask.
    always_comb begin
        done_s = 1'b0;
        succ_s = ST_IDLE;
        case (state_r)
            ST_POOL: begin
                done_s = pool_done & ~pool_start;
                succ_s = ST_DENSE1;
            end
            ST_DENSE1: begin
                done_s = dense1_done & ~dense1_start;
                succ_s = ST_DENSE2;
            end
            ST_DENSE2: begin
                done_s = dense2_done & ~dense2_start;
                succ_s = ST_ARGMAX;
            end
            ST_ARGMAX: begin
                done_s = max_done & ~max_start;
                succ_s = ST_DONE;
            end
            default: begin
                done_s = 1'b0;
                succ_s = ST_IDLE;
            end
        endcase
    end

    // Next state; a done in the last permitted cycle takes priority over expiry.
    always_comb begin
        if (state_r == ST_IDLE) begin
            next_s = start ? ST_POOL : ST_IDLE;
        end else if (!is_stage(state_r)) begin
            next_s = ST_IDLE;
        end else if (done_s) begin
            next_s = succ_s;
        end else if (expired_s) begin
            next_s = ST_ERROR;
        end else begin
            next_s = state_r;
        end
    end

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (next_s != state_r),
        .count   (is_stage(state_r)),
        .expired (expired_s)
    );

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pool_start   <= 1'b0;
            dense1_start <= 1'b0;
            dense2_start <= 1'b0;
            max_start    <= 1'b0;
            busy         <= 1'b0;
            nn_done      <= 1'b0;
            timeout_err  <= 1'b0;
            digit_out    <= 8'd0;
            cycle_count  <= '0;
        end else begin
            state_r      <= next_s;
            pool_start   <= (next_s == ST_POOL)   && (state_r != ST_POOL);
            dense1_start <= (next_s == ST_DENSE1) && (state_r != ST_DENSE1);
            dense2_start <= (next_s == ST_DENSE2) && (state_r != ST_DENSE2);
            max_start    <= (next_s == ST_ARGMAX) && (state_r != ST_ARGMAX);
            busy         <= (next_s != ST_IDLE);
            nn_done      <= (next_s == ST_DONE);

            if (accept_s) begin
                timeout_err <= 1'b0;
            end else if (next_s == ST_ERROR) begin
                timeout_err <= 1'b1;
            end else begin
                timeout_err <= timeout_err;
            end

            if ((state_r == ST_ARGMAX) && done_s) begin
                digit_out <= max_digit;
            end else begin
                digit_out <= digit_out;
            end

            if (accept_s) begin
                cycle_count <= '0;
            end else if (is_stage(state_r) && (cycle_count != {CNT_W{1'b1}})) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end else begin
                cycle_count <= cycle_count;
            end
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer built with a 16-cycle watchdog.
module tb_nn_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  done_v;
    logic [7:0]  max_digit;
    logic        pool_start, dense1_start, dense2_start, max_start;
    logic        busy, nn_done, timeout_err;
    logic [7:0]  digit_out;
    logic [2:0]  stage;
    logic [31:0] cycle_count;
    logic [3:0]  starts;

    int nvec = 0;
    int nerr = 0;

    assign starts = {max_start, dense2_start, dense1_start, pool_start};

    nn_layer_sequencer #(
        .TIMEOUT (16),
        .CNT_W   (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pool_done    (done_v[0]),
        .dense1_done  (done_v[1]),
        .dense2_done  (done_v[2]),
        .max_done     (done_v[3]),
        .max_digit    (max_digit),
        .pool_start   (pool_start),
        .dense1_start (dense1_start),
        .dense2_start (dense2_start),
        .max_start    (max_start),
        .busy         (busy),
        .digit_out    (digit_out),
        .nn_done      (nn_done),
        .timeout_err  (timeout_err),
        .stage        (stage),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected completion");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start a run and answer each stage's done continuously until target is reached.
    task automatic advance_to(input logic [2:0] target);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 60 && stage != target; i++) begin
            if (stage >= 3'd1 && stage <= 3'd4) done_v = 4'(1 << (stage - 3'd1));
            else                                 done_v = 4'b0000;
            step();
        end
        done_v = 4'b0000;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; done_v = 4'hF; max_digit = 8'd9;
        step(); step();
        nvec++;
        if ({stage, busy, nn_done, timeout_err, starts} !== {3'd0, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
            nerr++;
            $display("FAIL reset_ctrl: got stage=%0d busy=%b done=%b err=%b starts=%b expected 0 0 0 0 0000",
                     stage, busy, nn_done, timeout_err, starts);
        end
        nvec++;
        if ({digit_out, cycle_count} !== {8'd0, 32'd0}) begin
            nerr++;
            $display("FAIL reset_data: got digit=%0d count=%0d expected 0 0", digit_out, cycle_count);
        end
        reset = 1'b0; start = 1'b0; done_v = 4'b0000;
        step();
    endtask

    // Each done asserted in the cycle after launch: nn_done on the ninth edge counting the accept edge.
    task automatic test_nominal(input logic [7:0] d);
        int edges;
        logic [3:0] exp_v;
        max_digit = d;
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 1;
        for (int s = 1; s <= 4; s++) begin
            exp_v = 4'(1 << (s - 1));
            nvec++;
            if ({stage, starts, busy, nn_done, timeout_err} !== {3'(s), exp_v, 1'b1, 1'b0, 1'b0}) begin
                nerr++;
                $display("FAIL nominal_launch s=%0d: got stage=%0d starts=%b busy=%b done=%b err=%b expected stage=%0d starts=%b 1 0 0",
                         s, stage, starts, busy, nn_done, timeout_err, s, exp_v);
            end
            step(); edges++;
            nvec++;
            if ({stage, starts} !== {3'(s), 4'b0000}) begin
                nerr++;
                $display("FAIL nominal_second s=%0d: got stage=%0d starts=%b expected stage=%0d starts=0000",
                         s, stage, starts, s);
            end
            done_v = exp_v;
            step(); edges++;
            done_v = 4'b0000;
        end
        nvec++;
        if ({stage, nn_done, busy, starts, digit_out} !== {3'd5, 1'b1, 1'b1, 4'b0000, d}) begin
            nerr++;
            $display("FAIL nominal_done: got stage=%0d done=%b busy=%b starts=%b digit=%0d expected 5 1 1 0000 %0d",
                     stage, nn_done, busy, starts, digit_out, d);
        end
        nvec++;
        if (cycle_count !== 32'd8 || edges != 9) begin
            nerr++;
            $display("FAIL nominal_latency: got count=%0d edges=%0d expected count=8 edges=9", cycle_count, edges);
        end
        step();
        nvec++;
        if ({stage, busy, nn_done, digit_out, cycle_count} !== {3'd0, 1'b0, 1'b0, d, 32'd8}) begin
            nerr++;
            $display("FAIL nominal_idle: got stage=%0d busy=%b done=%b digit=%0d count=%0d expected 0 0 0 %0d 8",
                     stage, busy, nn_done, digit_out, cycle_count, d);
        end
    endtask

    task automatic test_timeout;
        int cycles;
        logic [7:0] prev;
        prev = digit_out;
        max_digit = 8'd1;
        advance_to(3'd2);
        done_v = 4'b1101;
        cycles = 1;
        for (int i = 0; i < 40 && stage == 3'd2; i++) begin
            step();
            if (stage == 3'd2) cycles++;
        end
        nvec++;
        if (cycles != 16 || stage !== 3'd6) begin
            nerr++;
            $display("FAIL timeout_entry: got dense1_cycles=%0d stage=%0d expected 16 6", cycles, stage);
        end
        nvec++;
        if ({timeout_err, nn_done, busy, starts} !== {1'b1, 1'b0, 1'b1, 4'b0000}) begin
            nerr++;
            $display("FAIL timeout_flags: got err=%b done=%b busy=%b starts=%b expected 1 0 1 0000",
                     timeout_err, nn_done, busy, starts);
        end
        step();
        done_v = 4'b0000;
        nvec++;
        if ({stage, timeout_err, nn_done, digit_out, cycle_count} !== {3'd0, 1'b1, 1'b0, prev, 32'd18}) begin
            nerr++;
            $display("FAIL timeout_idle: got stage=%0d err=%b done=%b digit=%0d count=%0d expected 0 1 0 %0d 18",
                     stage, timeout_err, nn_done, digit_out, cycle_count, prev);
        end
    endtask

    task automatic test_back_to_back;
        test_nominal(8'd3);
        test_nominal(8'd9);
        nvec++;
        if ({digit_out, timeout_err} !== {8'd9, 1'b0}) begin
            nerr++;
            $display("FAIL back_to_back: got digit=%0d err=%b expected 9 0", digit_out, timeout_err);
        end
    endtask

    // Done arriving exactly in the sixteenth DENSE2 cycle must still advance.
    task automatic test_boundary;
        int bad;
        max_digit = 8'd5;
        advance_to(3'd3);
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (stage !== 3'd3) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL boundary_hold: got %0d cycles outside DENSE2 expected 0", bad);
        end
        done_v = 4'b0100;
        step();
        done_v = 4'b0000;
        nvec++;
        if ({stage, timeout_err, max_start} !== {3'd4, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL boundary_advance: got stage=%0d err=%b max_start=%b expected 4 0 1",
                     stage, timeout_err, max_start);
        end
        done_v = 4'b1000;
        step(); step();
        done_v = 4'b0000;
        nvec++;
        if ({stage, nn_done, digit_out, cycle_count} !== {3'd5, 1'b1, 8'd5, 32'd22}) begin
            nerr++;
            $display("FAIL boundary_done: got stage=%0d done=%b digit=%0d count=%0d expected 5 1 5 22",
                     stage, nn_done, digit_out, cycle_count);
        end
        step();
    endtask

    task automatic test_start_held;
        int extra_pool;
        max_digit = 8'd2;
        start = 1'b1;
        step();
        done_v = 4'b0001;
        step();
        nvec++;
        if ({stage, pool_start} !== {3'd1, 1'b0}) begin
            nerr++;
            $display("FAIL held_launch_done: got stage=%0d pool_start=%b expected 1 0", stage, pool_start);
        end
        extra_pool = 0;
        for (int i = 0; i < 40 && stage != 3'd5; i++) begin
            if (stage >= 3'd1 && stage <= 3'd4) done_v = 4'(1 << (stage - 3'd1));
            else                                 done_v = 4'b0000;
            step();
            if (pool_start) extra_pool++;
        end
        done_v = 4'b0000;
        nvec++;
        if ({stage, nn_done, digit_out, cycle_count} !== {3'd5, 1'b1, 8'd2, 32'd8} || extra_pool != 0) begin
            nerr++;
            $display("FAIL held_run: got stage=%0d done=%b digit=%0d count=%0d restarts=%0d expected 5 1 2 8 0",
                     stage, nn_done, digit_out, cycle_count, extra_pool);
        end
        step();
        nvec++;
        if ({stage, busy} !== {3'd0, 1'b0}) begin
            nerr++;
            $display("FAIL held_idle: got stage=%0d busy=%b expected 0 0", stage, busy);
        end
        step();
        nvec++;
        if ({stage, pool_start, cycle_count} !== {3'd1, 1'b1, 32'd0}) begin
            nerr++;
            $display("FAIL held_restart: got stage=%0d pool_start=%b count=%0d expected 1 1 0",
                     stage, pool_start, cycle_count);
        end
        start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid;
        int bad;
        max_digit = 8'd6;
        advance_to(3'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        nvec++;
        if ({stage, busy, nn_done, timeout_err, starts, digit_out, cycle_count} !==
            {3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'd0, 32'd0}) begin
            nerr++;
            $display("FAIL reset_mid: got stage=%0d busy=%b done=%b err=%b starts=%b digit=%0d count=%0d expected all 0",
                     stage, busy, nn_done, timeout_err, starts, digit_out, cycle_count);
        end
        done_v = 4'hF;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (stage !== 3'd0 || starts !== 4'b0000 || nn_done !== 1'b0) bad++;
        end
        done_v = 4'b0000;
        nvec++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; done_v = 4'b0000; max_digit = 8'd0;
        test_reset();
        test_nominal(8'd7);
        test_timeout();
        test_back_to_back();
        test_boundary();
        test_start_held();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
